// File: rtl/sram_pkg.sv
// Shared definitions for the dual-port async SRAM controller: bus-cycle
// state encoding, owner encoding, default bus widths and a sizing helper.
package sram_pkg;

  // Default external SRAM geometry (RAM2 class part).
  localparam int DEFAULT_AW = 18;
  localparam int DEFAULT_DW = 16;

  // Bus-cycle phases. Every operation walks IDLE -> SETUP -> ACCESS -> HOLD -> IDLE.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Which pipeline stage owns the operation currently in flight.
  localparam logic OWN_IF  = 1'b0;
  localparam logic OWN_EXE = 1'b1;

  // Larger of two integers, used to size the shared phase counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sram_phase_cnt.sv
// Loadable down-counter with a zero flag. The controller loads it on entry
// to ACCESS and to HOLD and leaves the phase when the counter reads zero,
// so a load value of N-1 gives a phase N cycles long.
module sram_phase_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [CW-1:0] i_load_val,
  input  logic          i_dec,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  // Load has priority over decrement; the count saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sram_dual_port_ctrl.sv
// Controller for one external async SRAM shared by the IF and EXE stages.
// EXE wins arbitration. Each operation runs a SETUP cycle, ACCESS_CYC cycles
// with OE_n or WE_n low, then HOLD_CYC cycles with the strobes released while
// address (and write data) stay on the pins. Address, direction and write
// data are latched at grant so requesters may change them afterwards.
module sram_dual_port_ctrl
  import sram_pkg::*;
#(
  parameter int AW         = DEFAULT_AW,
  parameter int DW         = DEFAULT_DW,
  parameter int ACCESS_CYC = 1,
  parameter int HOLD_CYC   = 1
) (
  input  logic          clk,
  input  logic          rst,
  // instruction-fetch port (read only)
  input  logic          i_if_req,
  input  logic [AW-1:0] i_if_addr,
  output logic          o_if_done,
  output logic [DW-1:0] o_if_rdata,
  // execute port (read or write)
  input  logic          i_exe_req,
  input  logic          i_exe_we,
  input  logic [AW-1:0] i_exe_addr,
  input  logic [DW-1:0] i_exe_wdata,
  output logic          o_exe_done,
  output logic [DW-1:0] o_exe_rdata,
  // status
  output logic          o_busy,
  // SRAM pins
  output logic [AW-1:0] o_sram_addr,
  inout  wire  [DW-1:0] io_sram_dq,
  output logic          o_sram_en_n,
  output logic          o_sram_oe_n,
  output logic          o_sram_we_n
);

  // One counter serves both timed phases, so it is sized for the longer one.
  localparam int            CW        = $clog2(max_int(ACCESS_CYC, HOLD_CYC)) + 1;
  localparam logic [CW-1:0] ACC_LOAD  = CW'(ACCESS_CYC - 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYC - 1);

  state_t        r_state;
  state_t        w_state_next;

  logic          r_owner;
  logic          r_we;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_if_rdata;
  logic [DW-1:0] r_exe_rdata;
  logic          r_en_n;
  logic          r_oe_n;
  logic          r_we_n;
  logic          r_dq_oe;

  logic          w_grant_exe;
  logic          w_grant_if;
  logic          w_cnt_load;
  logic [CW-1:0] w_cnt_load_val;
  logic          w_cnt_dec;
  logic          w_cnt_zero;
  logic          w_capture;
  logic          w_last_hold;
  logic          w_we_eff;
  logic          w_en_n_next;
  logic          w_oe_n_next;
  logic          w_we_n_next;
  logic          w_dq_oe_next;

  sram_phase_cnt #(
    .CW (CW)
  ) u_phase_cnt (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_load_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Phase register; reset abandons any operation in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Arbitration, phase sequencing and counter control.
  always_comb begin
    w_state_next   = r_state;
    w_grant_exe    = 1'b0;
    w_grant_if     = 1'b0;
    w_cnt_load     = 1'b0;
    w_cnt_load_val = '0;
    w_cnt_dec      = 1'b0;
    w_capture      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_exe_req) begin
          w_grant_exe  = 1'b1;
          w_state_next = ST_SETUP;
        end else if (i_if_req) begin
          w_grant_if   = 1'b1;
          w_state_next = ST_SETUP;
        end
      end
      ST_SETUP: begin
        w_state_next   = ST_ACCESS;
        w_cnt_load     = 1'b1;
        w_cnt_load_val = ACC_LOAD;
      end
      ST_ACCESS: begin
        if (w_cnt_zero) begin
          // Read data is sampled on the edge that ends the strobe.
          w_state_next   = ST_HOLD;
          w_cnt_load     = 1'b1;
          w_cnt_load_val = HOLD_LOAD;
          w_capture      = ~r_we;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      ST_HOLD: begin
        if (w_cnt_zero) begin
          w_state_next = ST_IDLE;
        end else begin
          w_cnt_dec = 1'b1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Pin strobes are registered from the next phase so they change cleanly
  // with the state. OE_n and WE_n are mutually exclusive by construction,
  // and the data bus is only driven for writes, never alongside OE_n.
  always_comb begin
    w_we_eff     = w_grant_exe ? i_exe_we : (w_grant_if ? 1'b0 : r_we);
    w_en_n_next  = (w_state_next == ST_IDLE);
    w_oe_n_next  = ~((w_state_next == ST_ACCESS) && !r_we);
    w_we_n_next  = ~((w_state_next == ST_ACCESS) && r_we);
    w_dq_oe_next = (w_state_next != ST_IDLE) && w_we_eff;
  end

  // Pin strobe and bus-drive registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_en_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_dq_oe <= 1'b0;
    end else begin
      r_en_n  <= w_en_n_next;
      r_oe_n  <= w_oe_n_next;
      r_we_n  <= w_we_n_next;
      r_dq_oe <= w_dq_oe_next;
    end
  end

  // Latch owner, direction, address and write data at grant only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_grant_exe) begin
      r_owner <= OWN_EXE;
      r_we    <= i_exe_we;
      r_addr  <= i_exe_addr;
      r_wdata <= i_exe_wdata;
    end else if (w_grant_if) begin
      r_owner <= OWN_IF;
      r_we    <= 1'b0;
      r_addr  <= i_if_addr;
    end
  end

  // Capture read data into the owning port's register; writes leave both alone.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_rdata  <= '0;
      r_exe_rdata <= '0;
    end else if (w_capture) begin
      if (r_owner == OWN_EXE) begin
        r_exe_rdata <= io_sram_dq;
      end else begin
        r_if_rdata <= io_sram_dq;
      end
    end
  end

  // Done fires during the final HOLD cycle for whichever port owns the op.
  assign w_last_hold = (r_state == ST_HOLD) && w_cnt_zero;
  assign o_if_done   = w_last_hold && (r_owner == OWN_IF);
  assign o_exe_done  = w_last_hold && (r_owner == OWN_EXE);

  assign o_if_rdata  = r_if_rdata;
  assign o_exe_rdata = r_exe_rdata;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_sram_addr = r_addr;
  assign o_sram_en_n = r_en_n;
  assign o_sram_oe_n = r_oe_n;
  assign o_sram_we_n = r_we_n;
  assign io_sram_dq  = r_dq_oe ? r_wdata : {DW{1'bz}};

endmodule

// File: tb/tb_sram_dual_port_ctrl.sv
// Bench for sram_dual_port_ctrl. Two instances: index 0 uses default timing
// (ACCESS 1, HOLD 1), index 1 uses ACCESS 3, HOLD 2. Each has its own
// behavioural SRAM. Stimulus pushes expected done events (port, data, cycle)
// into a scoreboard queue; a monitor pops and compares on every done pulse.
module tb_sram_dual_port_ctrl;

  typedef struct {
    int          dut;
    bit          exe;
    logic [15:0] data;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  int          cyc = 0;

  logic        if_req    [2];
  logic [17:0] if_addr   [2];
  logic        exe_req   [2];
  logic        exe_we    [2];
  logic [17:0] exe_addr  [2];
  logic [15:0] exe_wdata [2];

  logic        if_done   [2];
  logic        exe_done  [2];
  logic [15:0] if_rdata  [2];
  logic [15:0] exe_rdata [2];
  logic        busy      [2];
  logic [17:0] sram_addr [2];
  logic        en_n      [2];
  logic        oe_n      [2];
  logic        we_n      [2];
  logic [15:0] dq_obs    [2];

  logic [15:0] ref_mem [2][64];
  logic [15:0] ref_exe [2];
  logic [15:0] ref_if  [2];

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   viol  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] init_val(input int d, input int i);
    if (d == 0 && i == 16) return 16'hBEEF;
    return 16'hA000 + 16'(d * 256) + 16'(i);
  endfunction

  // Posedges from issue until the done pulse is visible: SETUP + ACCESS + HOLD.
  function automatic int lat(input int d);
    return (d == 0) ? 3 : 6;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    wire  [15:0] dq;
    logic [15:0] mem [64];
    logic        l_if_done, l_exe_done, l_busy, l_en_n, l_oe_n, l_we_n;
    logic [15:0] l_if_rdata, l_exe_rdata;
    logic [17:0] l_addr;

    sram_dual_port_ctrl #(
      .AW         (18),
      .DW         (16),
      .ACCESS_CYC ((gi == 0) ? 1 : 3),
      .HOLD_CYC   ((gi == 0) ? 1 : 2)
    ) u_dut (
      .clk         (clk),
      .rst         (rst),
      .i_if_req    (if_req[gi]),
      .i_if_addr   (if_addr[gi]),
      .o_if_done   (l_if_done),
      .o_if_rdata  (l_if_rdata),
      .i_exe_req   (exe_req[gi]),
      .i_exe_we    (exe_we[gi]),
      .i_exe_addr  (exe_addr[gi]),
      .i_exe_wdata (exe_wdata[gi]),
      .o_exe_done  (l_exe_done),
      .o_exe_rdata (l_exe_rdata),
      .o_busy      (l_busy),
      .o_sram_addr (l_addr),
      .io_sram_dq  (dq),
      .o_sram_en_n (l_en_n),
      .o_sram_oe_n (l_oe_n),
      .o_sram_we_n (l_we_n)
    );

    // Async SRAM: drives the bus while selected with OE_n low.
    assign dq = (!l_en_n && !l_oe_n) ? mem[l_addr[5:0]] : 16'hzzzz;

    initial begin
      for (int i = 0; i < 64; i++) mem[i] <= init_val(gi, i);
    end

    always @(posedge clk) begin
      if (!l_en_n && !l_we_n) mem[l_addr[5:0]] <= dq;
    end

    assign if_done[gi]   = l_if_done;
    assign exe_done[gi]  = l_exe_done;
    assign if_rdata[gi]  = l_if_rdata;
    assign exe_rdata[gi] = l_exe_rdata;
    assign busy[gi]      = l_busy;
    assign sram_addr[gi] = l_addr;
    assign en_n[gi]      = l_en_n;
    assign oe_n[gi]      = l_oe_n;
    assign we_n[gi]      = l_we_n;
    assign dq_obs[gi]    = dq;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    tests++;
    if (act !== exp_v) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  // Monitor: pops the scoreboard on every done and checks strobe exclusivity.
  task automatic mon_step();
    exp_t        e;
    logic [15:0] act;
    bit          dn;
    for (int d = 0; d < 2; d++) begin
      if (!oe_n[d] && !we_n[d]) viol++;
      if (if_done[d] && exe_done[d]) viol++;
      for (int p = 0; p < 2; p++) begin
        dn  = (p == 1) ? exe_done[d] : if_done[d];
        act = (p == 1) ? exe_rdata[d] : if_rdata[d];
        if (dn) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_done: dut%0d port%0d at cycle %0d, no op outstanding", d, p, cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.dut != d || int'(e.exe) != p || e.data !== act || e.cyc != cyc) begin
              fails++;
              $display("FAIL done_check: got dut%0d port%0d data 0x%h cycle %0d, expected dut%0d port%0d data 0x%h cycle %0d",
                       d, p, act, cyc, e.dut, e.exe, e.data, e.cyc);
            end
          end
        end
      end
    end
  endtask

  // One arbitration round: optional EXE op and/or IF read issued together,
  // held until each port's done, dropped in the done cycle.
  task automatic round(input int d, input bit do_exe, input bit we, input logic [17:0] ea,
                       input logic [15:0] wd, input bit do_if, input logic [17:0] ia,
                       input bit mangle, output int oe_lo, output int we_lo, output bit dq_held);
    int   issue;
    bit   prev_we_n;
    exp_t e;
    oe_lo = 0; we_lo = 0; dq_held = 1'b0; prev_we_n = 1'b1;
    @(negedge clk);
    issue = cyc;
    if (do_exe) begin
      exe_we[d] = we; exe_addr[d] = ea; exe_wdata[d] = wd; exe_req[d] = 1'b1;
      if (we) ref_mem[d][ea[5:0]] = wd;
      else    ref_exe[d] = ref_mem[d][ea[5:0]];
      e.dut = d; e.exe = 1'b1; e.data = ref_exe[d]; e.cyc = issue + lat(d);
      exp_q.push_back(e);
    end
    if (do_if) begin
      if_addr[d] = ia; if_req[d] = 1'b1;
      ref_if[d] = ref_mem[d][ia[5:0]];
      e.dut = d; e.exe = 1'b0; e.data = ref_if[d];
      e.cyc = issue + (do_exe ? 2 * lat(d) + 1 : lat(d));
      exp_q.push_back(e);
    end
    for (int k = 0; k < 80 && (exe_req[d] || if_req[d]); k++) begin
      @(negedge clk);
      if (!oe_n[d]) oe_lo++;
      if (!we_n[d]) we_lo++;
      if (!prev_we_n && we_n[d] && !en_n[d]) dq_held = (dq_obs[d] == wd);
      prev_we_n = we_n[d];
      if (mangle && k == 0) begin
        exe_addr[d]  = 18'h00030;
        exe_wdata[d] = 16'hFFFF;
      end
      if (exe_done[d]) exe_req[d] = 1'b0;
      if (if_done[d])  if_req[d]  = 1'b0;
    end
    chk("round_timeout", {31'd0, exe_req[d] | if_req[d]}, 32'd0);
    exe_req[d] = 1'b0;
    if_req[d]  = 1'b0;
  endtask

  task automatic stimulus();
    int          oe_lo, we_lo, kind;
    bit          dh;
    logic [17:0] ra, rb;
    logic [15:0] rw;
    bit          rwe;

    rst = 1'b0;
    for (int d = 0; d < 2; d++) begin
      if_req[d] = 1'b0; if_addr[d] = '0; exe_req[d] = 1'b0; exe_we[d] = 1'b0;
      exe_addr[d] = '0; exe_wdata[d] = '0; ref_exe[d] = '0; ref_if[d] = '0;
      for (int i = 0; i < 64; i++) ref_mem[d][i] = init_val(d, i);
    end
    repeat (3) @(negedge clk);

    // Reset state of both instances.
    for (int d = 0; d < 2; d++) begin
      chk("rst_busy",      32'(busy[d]),      32'd0);
      chk("rst_en_n",      32'(en_n[d]),      32'd1);
      chk("rst_oe_n",      32'(oe_n[d]),      32'd1);
      chk("rst_we_n",      32'(we_n[d]),      32'd1);
      chk("rst_addr",      32'(sram_addr[d]), 32'd0);
      chk("rst_if_rdata",  32'(if_rdata[d]),  32'd0);
      chk("rst_exe_rdata", 32'(exe_rdata[d]), 32'd0);
    end
    rst = 1'b1;

    // IF read of 0x10 (holds 0xBEEF); OE_n low for exactly one cycle.
    round(0, 1'b0, 1'b0, 18'h0, 16'h0, 1'b1, 18'h00010, 1'b0, oe_lo, we_lo, dh);
    chk("t2_oe_low_cycles", 32'(oe_lo), 32'd1);
    chk("t2_we_low_cycles", 32'(we_lo), 32'd0);

    // EXE write then EXE read of 0x20; WE_n rises while data still driven.
    round(0, 1'b1, 1'b1, 18'h00020, 16'h1234, 1'b0, 18'h0, 1'b0, oe_lo, we_lo, dh);
    chk("t3_dq_held_at_we_rise", 32'(dh), 32'd1);
    chk("t3_we_low_cycles", 32'(we_lo), 32'd1);
    chk("t3_oe_low_cycles", 32'(oe_lo), 32'd0);
    round(0, 1'b1, 1'b0, 18'h00020, 16'h0, 1'b0, 18'h0, 1'b0, oe_lo, we_lo, dh);

    // Simultaneous requests: EXE first, IF four cycles later.
    round(0, 1'b1, 1'b0, 18'h00020, 16'h0, 1'b1, 18'h00010, 1'b0, oe_lo, we_lo, dh);
    chk("t4_oe_low_cycles", 32'(oe_lo), 32'd2);

    // Inputs changed after grant are ignored.
    round(0, 1'b1, 1'b1, 18'h00021, 16'h5A5A, 1'b0, 18'h0, 1'b1, oe_lo, we_lo, dh);
    round(0, 1'b1, 1'b0, 18'h00021, 16'h0, 1'b0, 18'h0, 1'b0, oe_lo, we_lo, dh);
    round(0, 1'b0, 1'b0, 18'h0, 16'h0, 1'b1, 18'h00030, 1'b0, oe_lo, we_lo, dh);

    // Reset in the middle of a write: no done, strobes released at once.
    @(negedge clk);
    exe_we[0] = 1'b1; exe_addr[0] = 18'h00005; exe_wdata[0] = 16'h7777; exe_req[0] = 1'b1;
    for (int k = 0; k < 10 && we_n[0]; k++) @(negedge clk);
    chk("t1_reached_access", 32'(we_n[0]), 32'd0);
    rst = 1'b0;
    exe_req[0] = 1'b0;
    @(negedge clk);
    chk("t1_we_n_after_rst",  32'(we_n[0]),     32'd1);
    chk("t1_en_n_after_rst",  32'(en_n[0]),     32'd1);
    chk("t1_busy_after_rst",  32'(busy[0]),     32'd0);
    chk("t1_no_exe_done",     32'(exe_done[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    ref_exe[0] = '0; ref_exe[1] = '0; ref_if[0] = '0; ref_if[1] = '0;
    @(negedge clk);
    chk("t1_idle_after_release", 32'(busy[0]),      32'd0);
    chk("t1_exe_rdata_cleared",  32'(exe_rdata[0]), 32'd0);
    // The aborted write never reached the array.
    round(0, 1'b1, 1'b0, 18'h00005, 16'h0, 1'b0, 18'h0, 1'b0, oe_lo, we_lo, dh);

    // Slow instance: directed read, then random mixed traffic.
    round(1, 1'b0, 1'b0, 18'h0, 16'h0, 1'b1, 18'h00003, 1'b0, oe_lo, we_lo, dh);
    chk("t5_oe_low_cycles", 32'(oe_lo), 32'd3);
    round(1, 1'b1, 1'b1, 18'h00004, 16'hC0DE, 1'b0, 18'h0, 1'b0, oe_lo, we_lo, dh);
    chk("t5_we_low_cycles", 32'(we_lo), 32'd3);
    chk("t5_dq_held_at_we_rise", 32'(dh), 32'd1);
    for (int n = 0; n < 1000; n++) begin
      kind = int'($urandom_range(0, 2));
      ra   = 18'($urandom_range(0, 15));
      rb   = 18'($urandom_range(0, 15));
      rw   = 16'($urandom);
      rwe  = 1'($urandom_range(0, 1));
      round(1, kind != 0, rwe, ra, rw, kind != 1, rb, 1'b0, oe_lo, we_lo, dh);
    end

    repeat (3) @(negedge clk);
    chk("no_strobe_or_done_overlap", 32'(viol), 32'd0);
    chk("all_dones_seen", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    fork
      begin
        forever begin
          @(negedge clk);
          mon_step();
        end
      end
      begin
        stimulus();
      end
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
